udp_payload_buffer: RTL and testbench

- Frame-committing payload store directly downstream of the combined IP/TCP/UDP decoder's UDP output (data_udp_out, wr_en_udp, len_udp_data, ok_udp, fin_udp, src_port_udp, dest_port_udp).
- Writes payload words speculatively and, when the decoder signals the end of a datagram, either commits the datagram or rolls it back.
- Commit requires a good checksum, correct length and no overflow.
- Presents committed datagrams on a word-read interface with a per-frame descriptor: byte length and ports.

---
 rtl/udp_payload_buffer.sv | 178 +++++++++++++++++
 tb/tb_udp_payload_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_payload_buffer.sv
// udp_payload_buffer: speculative UDP payload store with per-datagram commit/rollback.
// Ports: decoder side (data_in, wr_en, len_in, ports, ok_in, fin_in); reader side
// (rd_en -> rd_data/rd_valid/rd_last); head descriptor (frame_*); drop_cnt; full.
module udp_payload_buffer #(
  parameter int DEPTH_LOG2 = 9,
  parameter int DESC_LOG2  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        wr_en,
  input  logic [15:0] len_in,
  input  logic [15:0] src_port_in,
  input  logic [15:0] dst_port_in,
  input  logic        ok_in,
  input  logic        fin_in,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        rd_last,
  output logic        frame_valid,
  output logic [15:0] frame_len,
  output logic [15:0] frame_src_port,
  output logic [15:0] frame_dst_port,
  output logic [7:0]  drop_cnt,
  output logic        full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int NDESC = 1 << DESC_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DW    = DESC_LOG2 + 1;

  typedef struct packed {
    logic [15:0] len;
    logic [15:0] src;
    logic [15:0] dst;
  } desc_t;

  function automatic logic [14:0] words(input logic [15:0] l);
    return 15'(({1'b0, l} + 17'd3) >> 2);
  endfunction

  logic [31:0]   mem [DEPTH];
  desc_t         dq  [NDESC];

  logic [PW-1:0] wr_spec;
  logic [PW-1:0] wr_commit;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] used;
  logic [PW-1:0] spec_inc;
  logic [DW-1:0] dwr;
  logic [DW-1:0] drd;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] drd_nxt;
  logic [DW-1:0] dcnt_nxt;
  logic [15:0]   wc;
  logic [15:0]   wc_tot;
  logic          ovf;
  logic          ovf_tot;
  logic [14:0]   rc;
  logic [14:0]   req;
  logic [14:0]   head_req;
  logic          wr_ok;
  logic          wr_lost;
  logic          desc_full;
  logic          commit;
  logic          silent;
  logic          drop;
  logic          rd_ok;
  logic          rd_end;
  desc_t         desc_in;
  desc_t         head_nxt;

  assign used = wr_spec - rd_ptr;
  assign full = (used == PW'(DEPTH));

  always_comb begin
    wr_ok     = wr_en && !full;
    wr_lost   = wr_en && full;
    wc_tot    = wc + {15'd0, wr_ok};
    ovf_tot   = ovf | wr_lost;
    req       = words(len_in);
    desc_full = (dcnt == DW'(NDESC));
    commit    = fin_in && ok_in && !ovf_tot && (wc_tot == {1'b0, req})
                && (req != 15'd0) && !desc_full;
    // an empty, zero-length, good datagram carries nothing worth counting
    silent    = ok_in && !ovf_tot && (len_in == 16'd0) && (wc_tot == 16'd0);
    drop      = fin_in && !commit && !silent;
    spec_inc  = wr_spec + PW'(wr_ok);
    desc_in   = '{len: len_in, src: src_port_in, dst: dst_port_in};
  end

  always_comb begin
    head_req = words(frame_len);
    rd_ok    = rd_en && frame_valid;
    rd_end   = rd_ok && ((rc + 15'd1) == head_req);
    drd_nxt  = drd + DW'(rd_end);
    dcnt_nxt = dcnt + DW'(commit) - DW'(rd_end);
    head_nxt = '0;
    // a push into an empty (or just-emptied) FIFO becomes the head directly
    if (commit && dcnt_nxt == DW'(1))
      head_nxt = desc_in;
    else if (dcnt_nxt != '0)
      head_nxt = dq[drd_nxt[DESC_LOG2-1:0]];
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_spec[DEPTH_LOG2-1:0]] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (commit)
      dq[dwr[DESC_LOG2-1:0]] <= desc_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_spec   <= '0;
      wr_commit <= '0;
      wc        <= '0;
      ovf       <= 1'b0;
      dwr       <= '0;
      drop_cnt  <= '0;
    end else begin
      if (fin_in) begin
        wc  <= '0;
        ovf <= 1'b0;
        if (commit) begin
          wr_spec   <= spec_inc;
          wr_commit <= spec_inc;
        end else begin
          wr_spec <= wr_commit;
        end
      end else begin
        wc      <= wc_tot;
        ovf     <= ovf_tot;
        wr_spec <= spec_inc;
      end
      if (commit)
        dwr <= dwr + DW'(1);
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr         <= '0;
      rc             <= '0;
      rd_data        <= '0;
      rd_valid       <= 1'b0;
      rd_last        <= 1'b0;
      drd            <= '0;
      dcnt           <= '0;
      frame_valid    <= 1'b0;
      frame_len      <= '0;
      frame_src_port <= '0;
      frame_dst_port <= '0;
    end else begin
      rd_valid <= rd_ok;
      rd_last  <= rd_end;
      if (rd_ok) begin
        rd_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
        rd_ptr  <= rd_ptr + PW'(1);
        rc      <= rd_end ? 15'd0 : rc + 15'd1;
      end
      drd            <= drd_nxt;
      dcnt           <= dcnt_nxt;
      frame_valid    <= (dcnt_nxt != '0);
      frame_len      <= head_nxt.len;
      frame_src_port <= head_nxt.src;
      frame_dst_port <= head_nxt.dst;
    end
  end

endmodule

// File: tb/tb_udp_payload_buffer.sv
// tb_udp_payload_buffer: directed + random checks of udp_payload_buffer
// against a queue-based frame model.
module tb_udp_payload_buffer;

  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;
  localparam int NDESC = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_in = '0;
  logic        wr_en = 1'b0;
  logic [15:0] len_in = '0;
  logic [15:0] src_port_in = '0;
  logic [15:0] dst_port_in = '0;
  logic        ok_in = 1'b0;
  logic        fin_in = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        frame_valid;
  logic [15:0] frame_len;
  logic [15:0] frame_src_port;
  logic [15:0] frame_dst_port;
  logic [7:0]  drop_cnt;
  logic        full;

  always #5 clk = ~clk;

  udp_payload_buffer #(.DEPTH_LOG2(DL), .DESC_LOG2(3)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .wr_en(wr_en),
    .len_in(len_in), .src_port_in(src_port_in), .dst_port_in(dst_port_in),
    .ok_in(ok_in), .fin_in(fin_in), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_last(rd_last), .frame_valid(frame_valid),
    .frame_len(frame_len), .frame_src_port(frame_src_port),
    .frame_dst_port(frame_dst_port), .drop_cnt(drop_cnt), .full(full)
  );

  typedef struct { logic [31:0] data; logic last; } wexp_t;
  typedef struct { logic [15:0] len; logic [15:0] src; logic [15:0] dst; } dexp_t;

  wexp_t       exp_q[$];
  dexp_t       desc_q[$];
  logic [31:0] cur_q[$];
  bit          m_ovf;
  int          m_drop;
  int          n_tests;
  int          n_fail;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    desc_q.delete();
    cur_q.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic step();
    bit    acc_r;
    bit    cmt;
    int    req;
    wexp_t w;
    dexp_t d;
    acc_r = rd_en && desc_q.size() != 0;
    if (wr_en) begin
      if (exp_q.size() + cur_q.size() < DEPTH) cur_q.push_back(data_in);
      else m_ovf = 1'b1;
    end
    if (fin_in) begin
      req = (int'(len_in) + 3) / 4;
      cmt = ok_in && !m_ovf && cur_q.size() == req && req != 0
            && desc_q.size() < NDESC;
      if (cmt) begin
        foreach (cur_q[i]) begin
          w.data = cur_q[i];
          w.last = (i == cur_q.size() - 1);
          exp_q.push_back(w);
        end
        d.len = len_in;
        d.src = src_port_in;
        d.dst = dst_port_in;
        desc_q.push_back(d);
      end else if (!(ok_in && !m_ovf && len_in == 0 && cur_q.size() == 0)) begin
        if (m_drop < 255) m_drop++;
      end
      cur_q.delete();
      m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    check("rd_valid", 32'(rd_valid), 32'(acc_r));
    if (acc_r) begin
      w = exp_q.pop_front();
      check("rd_data", rd_data, w.data);
      check("rd_last", 32'(rd_last), 32'(w.last));
      if (w.last) void'(desc_q.pop_front());
    end else begin
      check("rd_last_idle", 32'(rd_last), 32'(0));
    end
    check("frame_valid", 32'(frame_valid), 32'(desc_q.size() != 0));
    if (desc_q.size() != 0) begin
      check("frame_len", 32'(frame_len), 32'(desc_q[0].len));
      check("frame_src", 32'(frame_src_port), 32'(desc_q[0].src));
      check("frame_dst", 32'(frame_dst_port), 32'(desc_q[0].dst));
    end
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("full", 32'(full), 32'((exp_q.size() + cur_q.size()) == DEPTH));
  endtask

  task automatic cyc(input bit w, input logic [31:0] dat, input bit f,
                     input logic [15:0] l, input bit ok,
                     input logic [15:0] s, input logic [15:0] t, input bit r);
    wr_en = w; data_in = dat; fin_in = f; len_in = l; ok_in = ok;
    src_port_in = s; dst_port_in = t; rd_en = r;
    step();
  endtask

  task automatic idle(input int n, input bit r);
    repeat (n) cyc(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, r);
  endtask

  task automatic send(input int nw, input logic [15:0] l, input bit ok,
                      input logic [15:0] s, input logic [15:0] t,
                      input logic [31:0] base, input bit r);
    if (nw == 0) cyc(1'b0, '0, 1'b1, l, ok, s, t, r);
    for (int i = 0; i < nw; i++)
      cyc(1'b1, base + 32'(i) * 32'h11111111, i == nw - 1, l, ok, s, t, r);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && desc_q.size() != 0; i++) idle(1, 1'b1);
    idle(1, 1'b0);
    check("drain_empty", 32'(frame_valid), 32'(0));
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_rd_data"}, rd_data, 32'(0));
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'(0));
    check({tag, "_rd_last"}, 32'(rd_last), 32'(0));
    check({tag, "_fvalid"}, 32'(frame_valid), 32'(0));
    check({tag, "_flen"}, 32'(frame_len), 32'(0));
    check({tag, "_src"}, 32'(frame_src_port), 32'(0));
    check({tag, "_dst"}, 32'(frame_dst_port), 32'(0));
    check({tag, "_drop"}, 32'(drop_cnt), 32'(0));
    check({tag, "_full"}, 32'(full), 32'(0));
  endtask

  initial begin
    int          d0;
    int          nw;
    logic [15:0] l;
    n_tests = 0;
    n_fail  = 0;
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    // basic good frame
    send(3, 16'd10, 1'b1, 16'h1234, 16'h5678, 32'h11111111, 1'b0);
    check("t1_len", 32'(frame_len), 32'(10));
    check("t1_src", 32'(frame_src_port), 32'h1234);
    check("t1_dst", 32'(frame_dst_port), 32'h5678);
    drain();
    check("t1_drop", 32'(drop_cnt), 32'(0));

    // bad checksum, then rollback proof
    send(3, 16'd10, 1'b0, 16'h1234, 16'h5678, 32'h11111111, 1'b0);
    check("t2_fv", 32'(frame_valid), 32'(0));
    check("t2_drop", 32'(drop_cnt), 32'(1));
    send(2, 16'd8, 1'b1, 16'h0001, 16'h0002, 32'hA0000000, 1'b0);
    drain();

    // overflow
    send(2, 16'd8, 1'b1, 16'h0A0A, 16'h0B0B, 32'h01020304, 1'b0);
    for (int i = 0; i < DEPTH - 2; i++)
      cyc(1'b1, 32'hC0000000 + 32'(i), 1'b0, 16'd60, 1'b1, 16'h3, 16'h4, 1'b0);
    check("t3_full", 32'(full), 32'(1));
    cyc(1'b1, 32'hDEADBEEF, 1'b1, 16'd60, 1'b1, 16'h3, 16'h4, 1'b0);
    check("t3_drop", 32'(drop_cnt), 32'(2));
    drain();
    check("t3_full_clr", 32'(full), 32'(0));

    // length mismatch and zero-length cases
    send(2, 16'd12, 1'b1, 16'h5, 16'h6, 32'h0F0F0F0F, 1'b0);
    check("t4_drop", 32'(drop_cnt), 32'(3));
    send(2, 16'd5, 1'b1, 16'h7, 16'h8, 32'h12345678, 1'b0);
    check("t4_len5", 32'(frame_len), 32'(5));
    drain();
    send(0, 16'd0, 1'b1, 16'h9, 16'h9, '0, 1'b0);
    check("t4_silent", 32'(drop_cnt), 32'(3));
    send(0, 16'd4, 1'b1, 16'h9, 16'h9, '0, 1'b0);
    check("t4_empty_drop", 32'(drop_cnt), 32'(4));

    // commit coinciding with pop of the last descriptor
    send(1, 16'd4, 1'b1, 16'h11, 16'h22, 32'h55555555, 1'b0);
    cyc(1'b1, 32'h66666666, 1'b1, 16'd3, 1'b1, 16'h33, 16'h44, 1'b1);
    check("t5_fv", 32'(frame_valid), 32'(1));
    check("t5_len", 32'(frame_len), 32'(3));
    drain();

    // random frames with a continuously requesting reader
    d0 = m_drop;
    for (int f = 0; f < 40; f++) begin
      l  = 16'($urandom_range(1, 16));
      nw = (int'(l) + 3) / 4;
      for (int i = 0; i < nw; i++)
        cyc(1'b1, $urandom, i == nw - 1, l, 1'b1,
            16'($urandom), 16'($urandom), 1'b1);
      idle($urandom_range(0, 2), 1'b1);
    end
    drain();
    check("t6_nodrop", 32'(drop_cnt), 32'(d0));

    // descriptor FIFO full
    d0 = m_drop;
    for (int f = 0; f < 9; f++)
      send(1, 16'd4, 1'b1, 16'(f), 16'(f + 100), 32'h70000000 + 32'(f), 1'b0);
    check("t7_drop9", 32'(drop_cnt), 32'(d0 + 1));
    drain();

    // async reset mid-frame and mid-read
    send(3, 16'd12, 1'b1, 16'hAA, 16'hBB, 32'h21212121, 1'b0);
    cyc(1'b1, 32'h99999999, 1'b0, 16'd8, 1'b1, 16'h1, 16'h2, 1'b1);
    cyc(1'b1, 32'h88888888, 1'b0, 16'd8, 1'b1, 16'h1, 16'h2, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("areset");
    model_clear();
    wr_en = 1'b0; fin_in = 1'b0; rd_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    send(2, 16'd7, 1'b1, 16'hCAFE, 16'hBEEF, 32'h0BAD0000, 1'b0);
    check("t8_len", 32'(frame_len), 32'(7));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
